// File: rtl/fdiv.sv
// fdiv: IEEE-754 binary32 divider built around a radix-2 restoring loop.
// Fixed 28-cycle cadence: one capture edge, 26 quotient-bit edges, and one
// rounding edge. Special operands are classified at capture and still walk
// the full pipeline, so latency never depends on the data.
module fdiv (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic [31:0] x,
  input  logic [31:0] y,
  output logic        busy,
  output logic        valid,
  output logic [31:0] rslt
);

  typedef enum logic [1:0] {S_IDLE, S_DIV, S_RND} state_t;
  typedef enum logic [1:0] {SP_NONE, SP_NAN, SP_INF, SP_ZERO} special_t;

  state_t             r_state, w_state_next;
  special_t           r_special, w_special;
  logic               r_sign;
  logic signed [9:0]  r_exp;
  logic [23:0]        r_divisor;
  logic [25:0]        r_rem;
  logic [25:0]        r_quo;
  logic [4:0]         r_cnt;
  logic               r_busy, r_valid;
  logic [31:0]        r_rslt;

  // Operand classification. Exponent 0 covers both true zero and subnormals,
  // which are flushed to zero.
  logic w_x_zero, w_x_inf, w_x_nan, w_y_zero, w_y_inf, w_y_nan;
  assign w_x_zero = (x[30:23] == 8'h00);
  assign w_y_zero = (y[30:23] == 8'h00);
  assign w_x_inf  = (x[30:23] == 8'hFF) && (x[22:0] == 23'd0);
  assign w_y_inf  = (y[30:23] == 8'hFF) && (y[22:0] == 23'd0);
  assign w_x_nan  = (x[30:23] == 8'hFF) && (x[22:0] != 23'd0);
  assign w_y_nan  = (y[30:23] == 8'hFF) && (y[22:0] != 23'd0);

  // Biased exponent difference, kept signed so under/overflow can be judged
  // after normalisation and rounding.
  logic signed [9:0] w_exp_init;
  assign w_exp_init = signed'({2'b00, x[30:23]}) - signed'({2'b00, y[30:23]}) + 10'sd127;

  // Classify the operand pair into the result class forced at rounding time.
  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can
    // leave it unassigned and infer a latch.
    w_special = SP_NONE;
    if (w_x_nan || w_y_nan || (w_x_zero && w_y_zero) || (w_x_inf && w_y_inf))
      w_special = SP_NAN;
    else if (w_x_inf || w_y_zero)
      w_special = SP_INF;
    else if (w_x_zero || w_y_inf)
      w_special = SP_ZERO;
  end

  // One restoring step: the partial remainder is always below twice the
  // divisor, so 25 bits of difference plus the shift fit in 26 bits.
  logic        w_ge;
  logic [24:0] w_trial;
  logic [25:0] w_rem_next;
  assign w_ge       = (r_rem >= {2'b00, r_divisor});
  assign w_trial    = r_rem[24:0] - {1'b0, r_divisor};
  assign w_rem_next = w_ge ? {w_trial, 1'b0} : {r_rem[24:0], 1'b0};

  // Normalise and round to nearest even from the 26-bit quotient.
  logic              w_norm, w_guard, w_sticky, w_round_up;
  logic [23:0]       w_mant;
  logic [24:0]       w_mant_rnd;
  logic [22:0]       w_frac;
  logic signed [9:0] w_exp_adj, w_exp_rnd;
  assign w_norm     = r_quo[25];
  assign w_mant     = w_norm ? r_quo[25:2] : r_quo[24:1];
  assign w_guard    = w_norm ? r_quo[1] : r_quo[0];
  assign w_sticky   = (w_norm & r_quo[0]) | (r_rem != 26'd0);
  assign w_round_up = w_guard & (w_sticky | w_mant[0]);
  assign w_mant_rnd = {1'b0, w_mant} + {24'd0, w_round_up};
  assign w_frac     = w_mant_rnd[24] ? w_mant_rnd[23:1] : w_mant_rnd[22:0];
  assign w_exp_adj  = w_norm ? r_exp : r_exp - 10'sd1;
  assign w_exp_rnd  = w_mant_rnd[24] ? w_exp_adj + 10'sd1 : w_exp_adj;

  // Assemble the final word, letting special classes and range limits win.
  logic [31:0] w_result;
  always_comb begin
    w_result = {r_sign, w_exp_rnd[7:0], w_frac};
    case (r_special)
      SP_NAN:  w_result = 32'h7FC0_0000;
      SP_INF:  w_result = {r_sign, 8'hFF, 23'd0};
      SP_ZERO: w_result = {r_sign, 31'd0};
      default: begin
        if (w_exp_rnd >= 10'sd255)
          w_result = {r_sign, 8'hFF, 23'd0};
        else if (w_exp_rnd <= 10'sd0)
          w_result = {r_sign, 31'd0};
      end
    endcase
  end

  // Next-state logic: IDLE accepts, DIV counts 26 bits, RND lasts one cycle.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (req) w_state_next = S_DIV;
      S_DIV:   if (r_cnt == 5'd25) w_state_next = S_RND;
      S_RND:   w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block ordering.
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_next;
  end

  // Datapath: capture operands, iterate the quotient, publish the result.
  always_ff @(posedge clk or posedge reset) begin
    // NOTE: the datapath is plain flops (no memory arrays), so clearing all of
    // it on reset is cheap and keeps abandoned operations from leaking out.
    if (reset) begin
      r_special <= SP_NONE;
      r_sign    <= 1'b0;
      r_exp     <= '0;
      r_divisor <= '0;
      r_rem     <= '0;
      r_quo     <= '0;
      r_cnt     <= '0;
      r_busy    <= 1'b0;
      r_valid   <= 1'b0;
      r_rslt    <= '0;
    end else begin
      r_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (req) begin
            r_special <= w_special;
            r_sign    <= x[31] ^ y[31];
            r_exp     <= w_exp_init;
            r_divisor <= {1'b1, y[22:0]};
            r_rem     <= {3'b001, x[22:0]};
            r_quo     <= '0;
            r_cnt     <= '0;
            r_busy    <= 1'b1;
          end
        end
        S_DIV: begin
          r_rem <= w_rem_next;
          r_quo <= {r_quo[24:0], w_ge};
          r_cnt <= r_cnt + 5'd1;
        end
        S_RND: begin
          r_rslt  <= w_result;
          r_valid <= 1'b1;
          r_busy  <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign busy  = r_busy;
  assign valid = r_valid;
  assign rslt  = r_rslt;

endmodule

// File: tb/tb_fdiv.sv
// Self-checking bench for fdiv: a scoreboard queue of expected results and
// due edges, filled when a request is accepted and drained on valid.
module tb_fdiv;

  logic        clk = 1'b0;
  logic        reset;
  logic        req;
  logic [31:0] x, y;
  logic        busy, valid;
  logic [31:0] rslt;

  fdiv dut (
    .clk   (clk),
    .reset (reset),
    .req   (req),
    .x     (x),
    .y     (y),
    .busy  (busy),
    .valid (valid),
    .rslt  (rslt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] res;
    int          due;
  } exp_t;

  exp_t        sb[$];
  int          cyc       = 0;
  int          acc_edge  = -1000;
  int          next_free = 0;
  logic [31:0] last_rslt = 32'd0;
  int          n_valid   = 0;
  int          n_checks  = 0;
  int          n_errors  = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h (edge %0d)", tag, got, exp, cyc);
    end
  endtask

  // Reference divider: wide integer division with exact remainder, then
  // round-to-nearest-even and range clamping.
  function automatic logic [31:0] fdiv_model(input logic [31:0] a, input logic [31:0] b);
    logic        s, a_zero, b_zero, a_inf, b_inf, a_nan, b_nan, g, st;
    logic [63:0] num, den, q, r, mant;
    int          e, sh;
    s      = a[31] ^ b[31];
    a_zero = (a[30:23] == 8'h00);
    b_zero = (b[30:23] == 8'h00);
    a_inf  = (a[30:23] == 8'hFF) && (a[22:0] == 23'd0);
    b_inf  = (b[30:23] == 8'hFF) && (b[22:0] == 23'd0);
    a_nan  = (a[30:23] == 8'hFF) && (a[22:0] != 23'd0);
    b_nan  = (b[30:23] == 8'hFF) && (b[22:0] != 23'd0);
    if (a_nan || b_nan || (a_zero && b_zero) || (a_inf && b_inf)) return 32'h7FC0_0000;
    if (a_inf || b_zero) return {s, 8'hFF, 23'd0};
    if (a_zero || b_inf) return {s, 31'd0};
    num = {40'd1, a[22:0]} << 40;
    den = {40'd1, b[22:0]};
    q   = num / den;
    r   = num % den;
    e   = int'(a[30:23]) - int'(b[30:23]) + 127;
    if (q[40]) sh = 17;
    else begin
      sh = 16;
      e  = e - 1;
    end
    mant = q >> sh;
    g    = q[sh-1];
    st   = ((q & ((64'd1 << (sh - 1)) - 64'd1)) != 64'd0) || (r != 64'd0);
    if (g && (st || mant[0])) mant = mant + 64'd1;
    if (mant[24]) begin
      mant = mant >> 1;
      e    = e + 1;
    end
    if (e >= 255) return {s, 8'hFF, 23'd0};
    if (e <= 0) return {s, 31'd0};
    return {s, e[7:0], mant[22:0]};
  endfunction

  function automatic logic [31:0] rand_operand(input int mode);
    logic [31:0] v;
    v = $urandom();
    case (mode)
      0:       v[30:23] = 8'($urandom_range(100, 154));
      1:       v[30:23] = 8'($urandom_range(1, 254));
      default: ;
    endcase
    return v;
  endfunction

  // Drive inputs for the coming edge and record an acceptance in the model.
  task automatic apply(input logic r, input logic [31:0] xv, input logic [31:0] yv,
                       input logic [31:0] expv);
    req = r;
    x   = xv;
    y   = yv;
    if (r && (cyc + 1 >= next_free)) begin
      sb.push_back('{res: expv, due: cyc + 28});
      acc_edge  = cyc + 1;
      next_free = cyc + 29;
    end
  endtask

  task automatic drive(input logic r, input logic [31:0] xv, input logic [31:0] yv,
                       input logic [31:0] expv);
    @(negedge clk);
    #1;
    apply(r, xv, yv, expv);
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 40; i++) begin
      if (sb.size() == 0) break;
      drive(1'b0, 32'd0, 32'd0, 32'd0);
    end
    check("drain", 32'(sb.size()), 32'd0);
  endtask

  // Per-cycle monitor: handshake timing, result, latency and hold behaviour.
  always @(negedge clk) begin : monitor
    exp_t ent;
    if (!reset) begin
      check("busy", 32'(busy), 32'((cyc >= acc_edge) && (cyc < acc_edge + 27)));
      check("valid", 32'(valid), 32'(cyc == acc_edge + 27));
      if (valid) begin
        n_valid++;
        if (sb.size() == 0) begin
          check("valid_without_req", 32'(valid), 32'd0);
        end else begin
          ent = sb.pop_front();
          check("rslt", rslt, ent.res);
          check("latency", 32'(cyc), 32'(ent.due));
          last_rslt = ent.res;
        end
      end else begin
        check("rslt_hold", rslt, last_rslt);
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  logic [31:0] dir_x [0:11];
  logic [31:0] dir_y [0:11];
  logic [31:0] dir_e [0:11];

  initial begin
    logic [31:0] xv, yv;
    int          t0, v0;

    dir_x = '{32'h40C00000, 32'h3F800000, 32'hBF800000, 32'h00000000,
              32'h7F800000, 32'h7F7FFFFF, 32'h00800000, 32'h00000001,
              32'h7FC00000, 32'h3F800000, 32'hC0000000, 32'h7F800000};
    dir_y = '{32'h40000000, 32'h40400000, 32'h00000000, 32'h00000000,
              32'h7F800000, 32'h3F000000, 32'h40000000, 32'h3F800000,
              32'h3F800000, 32'h7F800000, 32'h3F800000, 32'hBF800000};
    dir_e = '{32'h40400000, 32'h3EAAAAAB, 32'hFF800000, 32'h7FC00000,
              32'h7FC00000, 32'h7F800000, 32'h00000000, 32'h00000000,
              32'h7FC00000, 32'h00000000, 32'hC0000000, 32'hFF800000};

    reset = 1'b1;
    req   = 1'b0;
    x     = 32'd0;
    y     = 32'd0;
    repeat (2) @(negedge clk);
    #1;
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_valid", 32'(valid), 32'd0);
    check("reset_rslt", rslt, 32'd0);

    // Request on the very first edge after reset release.
    @(negedge clk);
    #1;
    reset = 1'b0;
    apply(1'b1, 32'h40C00000, 32'h40000000, 32'h40400000);
    wait_drain();

    // Directed operand classes, boundaries and specials.
    for (int i = 0; i < 12; i++) begin
      drive(1'b1, dir_x[i], dir_y[i], dir_e[i]);
      wait_drain();
    end

    // A request during busy must be ignored and leave the result intact.
    drive(1'b1, 32'h40C00000, 32'h40000000, 32'h40400000);
    repeat (4) drive(1'b0, 32'd0, 32'd0, 32'd0);
    drive(1'b1, 32'h41000000, 32'h40000000, 32'h40800000);
    wait_drain();

    // req held high: only edges T0 and T0+28 accept; two results by T55.
    v0 = n_valid;
    for (int i = 0; i < 56; i++) begin
      xv = rand_operand(0);
      yv = rand_operand(0);
      drive(1'b1, xv, yv, fdiv_model(xv, yv));
    end
    drive(1'b0, 32'd0, 32'd0, 32'd0);
    check("b2b_valid_count", 32'(n_valid - v0), 32'd2);
    wait_drain();

    // Reset at T10 of an operation abandons it; the next op runs normally.
    drive(1'b1, 32'h40C00000, 32'h40000000, 32'h40400000);
    t0 = acc_edge;
    while (cyc < t0 + 9) drive(1'b0, 32'd0, 32'd0, 32'd0);
    @(posedge clk);
    #2;
    reset = 1'b1;
    sb.delete();
    acc_edge  = -1000;
    next_free = 0;
    last_rslt = 32'd0;
    #1;
    check("async_reset_busy", 32'(busy), 32'd0);
    check("async_reset_valid", 32'(valid), 32'd0);
    check("async_reset_rslt", rslt, 32'd0);
    repeat (2) @(negedge clk);
    #1;
    reset = 1'b0;
    apply(1'b1, 32'h3F800000, 32'h40400000, 32'h3EAAAAAB);
    wait_drain();

    // Random operands across mid-range, full-range and raw bit patterns.
    for (int i = 0; i < 24; i++) begin
      xv = rand_operand(i % 3);
      yv = rand_operand((i + 1) % 3);
      drive(1'b1, xv, yv, fdiv_model(xv, yv));
      wait_drain();
    end

    repeat (3) drive(1'b0, 32'd0, 32'd0, 32'd0);
    check("sb_empty", 32'(sb.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/fdiv.md
FDIV -- requirements
Module: fdiv

Interface
REQ-001 The block SHALL have no parameters; widths are fixed to IEEE-754 binary32.
REQ-002 The block SHALL use one clock and an asynchronous, active-high reset: clk and reset.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-high; clears all state immediately.
REQ-005 req  input  1  start request; sampled on rising clk only when busy=0.
REQ-006 x  input  32  dividend, binary32; captured on the accepted req edge.
REQ-007 y  input  32  divisor, binary32; captured on the accepted req edge.
REQ-008 busy  output  1  high from the edge after acceptance through the result edge.
REQ-009 valid  output  1  one-cycle pulse; rslt holds the new quotient while high.
REQ-010 rslt  output  32  quotient x/y, binary32; holds its value until the next result.

Function
REQ-011 States SHALL be IDLE -> DIV -> RND -> IDLE, with no other transitions except reset to IDLE.
REQ-012 IDLE with req=1: capture sign, exponents and mantissas; set busy=1; load iteration counter=0; go to DIV.
REQ-013 req while busy=1 SHALL be ignored, with no queuing and no effect on the operation in flight.
REQ-014 DIV SHALL run exactly 26 cycles of radix-2 restoring division, one quotient bit per cycle, MSB first.
  - Operands: mantissa {hidden,frac[22:0]}.
  - 26-bit quotient, 25-bit partial remainder plus 1 bit.
REQ-015 Subnormal inputs (exp=0, frac!=0) SHALL be treated as signed zero (flush-to-zero).
REQ-016 Exponent SHALL be computed as a 10-bit signed value: e = ex - ey + 127.
  - If quotient bit 25 = 0, shift the quotient left 1 and apply e-1.
REQ-017 Rounding SHALL be round-to-nearest-even.
  - LSB = frac bit 0; guard = next quotient bit; sticky = OR of the remaining quotient bits and (remainder != 0).
  - Mantissa carry-out SHALL increment e.
REQ-018 After rounding, e >= 255 SHALL give signed infinity.
  - e <= 0 SHALL give signed zero (no subnormal outputs).
REQ-019 Result sign SHALL be x[31]^y[31] for all non-NaN results.
REQ-020 Special cases, decided at capture and applied in RND:
  - Any NaN operand, 0/0, or inf/inf -> 0x7FC00000.
  - finite/0 and inf/finite -> signed inf.
  - 0/finite and finite/inf -> signed zero.
REQ-021 Latency SHALL be fixed for every operand class including specials: req accepted at edge T0 gives valid=1 and rslt updated at edge T27.
  - busy=1 from T1 through T27.
  - busy=0 after T28.
REQ-022 At T28 the FSM SHALL be in IDLE, and req sampled at T28 SHALL be accepted (back-to-back throughput one op per 28 cycles).
REQ-023 valid SHALL be high for exactly one cycle per accepted req.

Reset
REQ-024 Reset asserted SHALL immediately force:
  - state=IDLE, busy=0, valid=0, rslt=0x00000000;
  - counter and datapath registers=0.
REQ-025 Reset mid-operation SHALL abandon the operation with no valid pulse.
  - After deassertion, the first req SHALL be accepted normally.
REQ-026 req sampled on the first clk edge after reset deassertion SHALL be accepted.

Verification
REQ-027 0x40C00000 / 0x40000000 (6.0/2.0) -> rslt=0x40400000, valid at T27 only.
REQ-028 0x3F800000 / 0x40400000 (1/3) -> 0x3EAAAAAB (round up, guard=1, sticky=1).
REQ-029 Divide-by-zero and NaN cases:
  - 0xBF800000 / 0x00000000 -> 0xFF800000.
  - 0x00000000 / 0x00000000 -> 0x7FC00000.
  - 0x7F800000 / 0x7F800000 -> 0x7FC00000.
  - All at fixed latency T27.
REQ-030 Overflow and underflow cases:
  - 0x7F7FFFFF / 0x3F000000 -> 0x7F800000.
  - 0x00800000 / 0x40000000 -> 0x00000000.
  - 0x00000001 / 0x3F800000 -> 0x00000000.
REQ-031 Busy and back-to-back behaviour:
  - req held high every cycle from T0 -> only ops at T0 and T28 accepted.
  - Exactly two valid pulses by T55.
  - A second req with different x at T5 has no effect on the first result.
REQ-032 Reset asserted at T10 of a 6.0/2.0 op:
  - busy, valid and rslt go to 0 immediately, with no valid pulse.
  - A new req after deassertion completes exactly 27 edges later.
